fp_div_sequencer: RTL and testbench

Upstream issue/return stage for the bfloat16 divider (fp_div). It accepts operand pairs over a ready/valid handshake and queues them in a small FIFO. It issues one division at a time as a single-cycle start pulse, holding the operands stable until the divider's valid pulse. It then returns the quotient, flags and a caller tag over a ready/valid output handshake, and aborts hung operations with a timeout.

---
 rtl/fp_div_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_fp_div_sequencer.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_sequencer.sv
// fp_div_sequencer
//   Issue/return stage in front of the bfloat16 divider (fp_div).
//   - Caller side: operand pairs plus a tag come in over a ready/valid
//     handshake and are queued in a DEPTH-entry FIFO.
//   - Divider side: one operation at a time is launched with a one-cycle
//     div_start pulse. div_opA/div_opB stay stable until div_valid comes back.
//   - Result side: the quotient, its flags and the caller tag are held on a
//     ready/valid output until the consumer accepts them.
//   - An operation that gets no div_valid within TIMEOUT cycles is aborted.
//     It returns the canonical NaN 16'h7FC0 with out_err set.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready = FIFO not full)
//   in_a, in_b        bfloat16 dividend / divisor
//   in_tag            caller tag, returned unmodified with the result
//   div_start         one-cycle launch pulse to the divider
//   div_opA, div_opB  registered operands to the divider
//   div_quotient      divider result
//   div_underflow,
//   div_overflow,
//   div_inexact       divider status flags
//   div_valid         one-cycle result strobe from the divider
//   out_valid/out_ready  result handshake
//   out_result        quotient, or 16'h7FC0 on timeout
//   out_flags         {underflow, overflow, inexact}
//   out_err           1 when the operation timed out
//   out_tag           tag of the returned operation
//   count             FIFO occupancy
//   busy              an operation is queued or in progress
module fp_div_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_a,
    input  logic [15:0]              in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     div_start,
    output logic [15:0]              div_opA,
    output logic [15:0]              div_opB,
    input  logic [15:0]              div_quotient,
    input  logic                     div_underflow,
    input  logic                     div_overflow,
    input  logic                     div_inexact,
    input  logic                     div_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_result,
    output logic [2:0]               out_flags,
    output logic                     out_err,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(TIMEOUT);
    localparam int ENTRY_W = 32 + TAG_W;

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1);
    localparam logic [15:0]      NAN_RESULT = 16'h7FC0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [15:0]         op_a_q, op_a_d;
    logic [15:0]         op_b_q, op_b_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [15:0]         result_q, result_d;
    logic [2:0]          flags_q, flags_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic [ENTRY_W-1:0]  fifo_mem [DEPTH];
    logic [ENTRY_W-1:0]  head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    // Operand storage. The head is read straight into the operand/tag
    // registers, so the registered read lives in op_a_q/op_b_q/tag_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {in_a, in_b, in_tag};
        end
    end

    assign head = fifo_mem[rd_ptr_q];

    always_comb begin
        fifo_full  = (count_q == DEPTH_CNT);
        fifo_empty = (count_q == '0);
        // A full FIFO refuses the push even if the head leaves this cycle.
        push       = in_valid && !fifo_full;
        // The head is taken when leaving IDLE, or when a response is
        // accepted and more work is queued (straight back to ISSUE).
        pop        = !fifo_empty &&
                     ((state_q == S_IDLE) || (state_q == S_RESP && out_ready));
    end

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Sequencer next state and datapath
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        tag_d      = tag_q;
        result_d   = result_q;
        flags_d    = flags_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;

        if (pop) begin
            op_a_d = head[ENTRY_W-1 -: 16];
            op_b_d = head[TAG_W +: 16];
            tag_d  = head[TAG_W-1:0];
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A result in the final WAIT cycle still beats the timeout.
                if (div_valid) begin
                    result_d = div_quotient;
                    flags_d  = {div_underflow, div_overflow, div_inexact};
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    result_d = NAN_RESULT;
                    flags_d  = 3'b000;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = fifo_empty ? S_IDLE : S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            tag_q      <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            tag_q      <= tag_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign in_ready   = !fifo_full;
    assign div_start  = (state_q == S_ISSUE);
    assign div_opA    = op_a_q;
    assign div_opB    = op_b_q;
    assign out_valid  = (state_q == S_RESP);
    assign out_result = result_q;
    assign out_flags  = flags_q;
    assign out_err    = err_q;
    assign out_tag    = tag_q;
    assign count      = count_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// tb_fp_div_sequencer
//   Drives randomized and directed operand streams into fp_div_sequencer.
//   A behavioural divider answers each div_start after a per-operation
//   latency, or never (lat == 0). Results are checked in acceptance order
//   against a queue-based reference computed with real arithmetic.
module tb_fp_div_sequencer;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;

    // lat: divider response delay in cycles after div_start; 0 = never answers
    typedef struct packed {
        logic [15:0]      a;
        logic [15:0]      b;
        logic [TAG_W-1:0] tag;
        int               lat;
    } op_t;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [15:0]            in_a;
    logic [15:0]            in_b;
    logic [TAG_W-1:0]       in_tag;
    logic                   div_start;
    logic [15:0]            div_opA;
    logic [15:0]            div_opB;
    logic [15:0]            div_quotient;
    logic                   div_underflow;
    logic                   div_overflow;
    logic                   div_inexact;
    logic                   div_valid;
    logic                   out_valid;
    logic                   out_ready;
    logic [15:0]            out_result;
    logic [2:0]             out_flags;
    logic                   out_err;
    logic [TAG_W-1:0]       out_tag;
    logic [$clog2(DEPTH):0] count;
    logic                   busy;

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  exp_start_cyc = -1;
    int  n_done = 0;
    int  n_timeouts = 0;
    int  rdy_mode = 0;     // 0 random, 1 hold low, 2 hold high
    bit  stray_req = 0;
    logic [15:0]      last_result;
    logic [2:0]       last_flags;
    logic             last_err;
    logic [TAG_W-1:0] last_tag;
    op_t iss_q[$];
    op_t res_q[$];

    fp_div_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .div_start(div_start), .div_opA(div_opA), .div_opB(div_opB),
        .div_quotient(div_quotient), .div_underflow(div_underflow),
        .div_overflow(div_overflow), .div_inexact(div_inexact),
        .div_valid(div_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_err(out_err),
        .out_tag(out_tag), .count(count), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got=still running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    // Normal bfloat16 values only; the stimulus never produces zero/inf/NaN.
    function automatic real bf2real(input logic [15:0] x);
        logic [63:0] d;
        d = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'b0};
        return $bitstoreal(d);
    endfunction

    // Quotient truncated to bfloat16; returns {underflow, overflow, inexact, q}
    function automatic logic [18:0] div_model(input logic [15:0] a, input logic [15:0] b);
        real         q;
        logic [63:0] d;
        int          e8;
        logic [15:0] r;
        logic [2:0]  f;
        q  = bf2real(a) / bf2real(b);
        d  = $realtobits(q);
        e8 = int'(d[62:52]) - 896;
        f  = 3'b000;
        if (e8 >= 255) begin
            r = {d[63], 8'hFF, 7'h00};
            f = 3'b011;
        end else if (e8 <= 0) begin
            r = {d[63], 15'h0000};
            f = 3'b101;
        end else begin
            r    = {d[63], e8[7:0], d[51:45]};
            f[0] = |d[44:0];
        end
        return {f, r};
    endfunction

    function automatic logic [15:0] rand_bf();
        logic [7:0] e;
        if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(1, 254));
        else                           e = 8'($urandom_range(120, 134));
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    // ---------------- behavioural divider ----------------
    initial begin
        int          st;
        int          cnt;
        op_t         cur;
        logic [18:0] r;
        st = 0;
        cnt = 0;
        cur = '0;
        div_valid = 1'b0;
        div_quotient = 16'h0;
        div_underflow = 1'b0;
        div_overflow = 1'b0;
        div_inexact = 1'b0;
        forever begin
            @(negedge clk);
            div_valid = 1'b0;
            if (reset) begin
                st = 0;
                continue;
            end
            if (cyc == exp_start_cyc) chk("b2b_issue", 32'(div_start), 32'd1);
            case (st)
                0: begin
                    if (div_start) begin
                        if (iss_q.size() == 0) begin
                            chk("spurious_start", 32'(div_start), 32'd0);
                        end else begin
                            cur = iss_q.pop_front();
                            chk("opA", 32'(div_opA), 32'(cur.a));
                            chk("opB", 32'(div_opB), 32'(cur.b));
                            cnt = 0;
                            st = 1;
                        end
                    end else if (stray_req) begin
                        stray_req = 0;
                        div_quotient = 16'hDEAD;
                        {div_underflow, div_overflow, div_inexact} = 3'b111;
                        div_valid = 1'b1;
                    end
                end
                1: begin
                    cnt++;
                    if (cnt == 1) chk("start_pulse", 32'(div_start), 32'd0);
                    chk("op_hold", {div_opA, div_opB}, {cur.a, cur.b});
                    if (cur.lat == 0) begin
                        if (out_valid) begin
                            chk("timeout_cyc", 32'(cnt), 32'(TIMEOUT + 1));
                            // late answer lands while the NaN response is pending
                            div_quotient = 16'hBEEF;
                            {div_underflow, div_overflow, div_inexact} = 3'b111;
                            div_valid = 1'b1;
                            st = 0;
                        end else if (cnt > TIMEOUT + 4) begin
                            chk("timeout_cyc", 32'(cnt), 32'(TIMEOUT + 1));
                            st = 0;
                        end
                    end else if (cnt == cur.lat) begin
                        chk("early_out", 32'(out_valid), 32'd0);
                        r = div_model(cur.a, cur.b);
                        div_quotient = r[15:0];
                        {div_underflow, div_overflow, div_inexact} = r[18:16];
                        div_valid = 1'b1;
                        st = 2;
                    end
                end
                default: begin
                    chk("resp_lat", 32'(out_valid), 32'd1);
                    st = 0;
                end
            endcase
        end
    end

    // ---------------- consumer / scoreboard ----------------
    initial begin
        op_t         e;
        logic [18:0] r;
        logic [15:0] exp_res;
        logic [2:0]  exp_flags;
        logic        exp_err;
        logic [24:0] saved;
        bit          prev_hold;
        prev_hold = 0;
        saved = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                out_ready = 1'b0;
                prev_hold = 0;
                continue;
            end
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
            if (prev_hold)
                chk("resp_hold", 32'({out_valid, out_result, out_flags, out_err, out_tag}), 32'(saved));
            if (out_valid && out_ready) begin
                if (res_q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = res_q.pop_front();
                    if (e.lat == 0) begin
                        exp_res = 16'h7FC0;
                        exp_flags = 3'b000;
                        exp_err = 1'b1;
                    end else begin
                        r = div_model(e.a, e.b);
                        exp_res = r[15:0];
                        exp_flags = r[18:16];
                        exp_err = 1'b0;
                    end
                    chk("result", 32'(out_result), 32'(exp_res));
                    chk("flags", 32'(out_flags), 32'(exp_flags));
                    chk("err", 32'(out_err), 32'(exp_err));
                    chk("tag", 32'(out_tag), 32'(e.tag));
                    $display("resp tag=%0d a=%h b=%h result=%h flags=%b err=%b",
                             out_tag, e.a, e.b, out_result, out_flags, out_err);
                    last_result = out_result;
                    last_flags = out_flags;
                    last_err = out_err;
                    last_tag = out_tag;
                    n_done++;
                    if (out_err) n_timeouts++;
                    if (count != 0) exp_start_cyc = cyc + 1;
                end
            end
            prev_hold = out_valid && !out_ready;
            saved = {1'b1, out_result, out_flags, out_err, out_tag};
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic enqueue(input logic [15:0] a, input logic [15:0] b,
                           input logic [TAG_W-1:0] t, input int lat);
        op_t o;
        o.a = a;
        o.b = b;
        o.tag = t;
        o.lat = lat;
        iss_q.push_back(o);
        res_q.push_back(o);
    endtask

    task automatic push_op(input logic [15:0] a, input logic [15:0] b,
                           input logic [TAG_W-1:0] t, input int lat);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = t;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (in_ready) begin
                enqueue(a, b, t, lat);
                done = 1;
            end
            step();
        end
        in_valid = 1'b0;
        if (!done) chk("push_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000; i++) begin
            if (res_q.size() == 0 && !busy) break;
            step();
        end
        chk("drain", 32'(res_q.size()) + 32'(busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int accepted;
        int lat;
        int sel;
        reset = 1'b1;
        in_valid = 1'b0;
        in_a = 16'h0;
        in_b = 16'h0;
        in_tag = '0;
        repeat (3) step();

        // reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(div_start), 32'd0);
        chk("rst_ops", {div_opA, div_opB}, 32'd0);
        chk("rst_out", 32'({out_valid, out_result, out_flags, out_err, out_tag}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        step();

        // single op: 6.0 / 2.0, tag 3
        in_valid = 1'b1;
        in_a = 16'h40C0;
        in_b = 16'h4000;
        in_tag = 4'd3;
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        enqueue(16'h40C0, 16'h4000, 4'd3, 3);
        step();
        in_valid = 1'b0;
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_start_early", 32'(div_start), 32'd0);
        step();
        chk("t1_start", 32'(div_start), 32'd1);
        chk("t1_popped", 32'(count), 32'd0);
        wait_idle();
        chk("t1_result", 32'(last_result), 32'h4040);
        chk("t1_tag", 32'(last_tag), 32'd3);
        chk("t1_flags", 32'({last_flags, last_err}), 32'd0);

        // fill with consumer stalled: 6 offers, 5 accepted
        rdy_mode = 1;
        accepted = 0;
        base = n_done;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a = rand_bf();
            in_b = rand_bf();
            in_tag = 4'(i);
            if (in_ready) begin
                enqueue(in_a, in_b, in_tag, 2);
                accepted++;
            end
            step();
        end
        in_valid = 1'b0;
        chk("fill_accepted", 32'(accepted), 32'd5);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk("fill_resp", 32'(out_valid), 32'd1);
        chk("fill_count2", 32'(count), 32'd4);

        // response pop while full: the offered op must wait one cycle
        in_valid = 1'b1;
        in_a = 16'h3F80;
        in_b = 16'h4000;
        in_tag = 4'd5;
        rdy_mode = 2;
        step();
        chk("full_hs", 32'(out_valid && out_ready), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("pop_at_full", 32'(count), 32'd3);
        chk("refill_ready", 32'(in_ready), 32'd1);
        enqueue(in_a, in_b, in_tag, 1);
        step();
        in_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd4);
        wait_idle();
        chk("fill_returned", 32'(n_done - base), 32'd6);
        chk("fill_last_tag", 32'(last_tag), 32'd5);
        rdy_mode = 0;

        // timeout, then a result in the last WAIT cycle, then a normal op
        base = n_timeouts;
        push_op(16'h4100, 16'h3F80, 4'd9, 0);
        push_op(16'h4000, 16'h4000, 4'd10, TIMEOUT);
        push_op(16'h4040, 16'h3F80, 4'd11, 2);
        wait_idle();
        chk("to_count", 32'(n_timeouts - base), 32'd1);
        chk("to_next_tag", 32'(last_tag), 32'd11);
        chk("to_next_err", 32'(last_err), 32'd0);

        // inexact 1/3, then a stray div_valid while idle
        push_op(16'h3F80, 16'h4040, 4'd7, 4);
        wait_idle();
        chk("inexact_flag", 32'(last_flags[0]), 32'd1);
        chk("inexact_tag", 32'(last_tag), 32'd7);
        stray_req = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stray_idle", 32'({out_valid, busy}), 32'd0);
        end

        // reset with one op hung in WAIT and two queued
        rdy_mode = 1;
        push_op(rand_bf(), rand_bf(), 4'd1, 0);
        push_op(rand_bf(), rand_bf(), 4'd2, 0);
        push_op(rand_bf(), rand_bf(), 4'd3, 0);
        repeat (3) step();
        chk("pre_rst_count", 32'(count), 32'd2);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ops", {div_opA, div_opB}, 32'd0);
        chk("arst_out", 32'({div_start, out_valid, out_result, out_flags, out_err, out_tag}), 32'd0);
        iss_q.delete();
        res_q.delete();
        exp_start_cyc = -1;
        step();
        step();
        reset = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("post_rst_quiet", 32'({out_valid, div_start, busy}), 32'd0);
        end

        // randomized stream, covers pointer wrap many times
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 15);
            if (sel == 0)      lat = 0;
            else if (sel == 1) lat = TIMEOUT;
            else               lat = $urandom_range(1, 6);
            push_op(rand_bf(), rand_bf(), 4'($urandom), lat);
            repeat ($urandom_range(0, 2)) step();
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
